// File: rtl/pc_unit_pkg.sv
// Shared types for the program-counter stage: FSM states, next-PC select codes
// and the sequential increment.
package pc_unit_pkg;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        PEND = 2'd1,
        HALT = 2'd2
    } pc_state_t;

    typedef enum logic [2:0] {
        SEL_EXC   = 3'd0,
        SEL_REDIR = 3'd1,
        SEL_PEND  = 3'd2,
        SEL_RAS   = 3'd3,
        SEL_SEQ   = 3'd4,
        SEL_HOLD  = 3'd5
    } pc_sel_t;

    localparam int PC_INC = 4;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the oldest
// entry; push and pop together replace the top in place.
module pc_ras #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] top,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_top;
    logic [PW:0]   cnt;
    logic          do_pop;

    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign ptr_top = ptr - PW'(1);
    assign top     = mem[ptr_top];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr <= '0;
            cnt <= '0;
        end else if (push && !do_pop) begin
            ptr <= ptr + PW'(1);
            if (cnt != FULL) cnt <= cnt + (PW+1)'(1);
        end else if (do_pop && !push) begin
            ptr <= ptr_top;
            cnt <= cnt - (PW+1)'(1);
        end
    end

    // Contents need no reset: cnt=0 makes every entry unreachable.
    always_ff @(posedge clk) begin
        if (push) mem[do_pop ? ptr_top : ptr] <= din;
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage with prioritised next-PC select, held redirects, halt
// and IF/ID flush. Optional return-address stack under PC_UNIT_RAS_EN.
//
// state | meaning
// RUN   | normal fetch
// PEND  | redirect seen during a stall, held in pend_target
// HALT  | fetch stopped, left only by exception or redirect with pc_wr
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_VEC = PC_W'(32'h0000_3000),
    parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_4180),
    parameter int              RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_wr,
    input  logic            redir_valid,
    input  logic [PC_W-1:0] redir_target,
    input  logic            exc_valid,
    input  logic            halt_req,
    input  logic            call_push,
    input  logic            ret_pop,
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus4,
    output logic            fetch_valid,
    output logic            flush,
    output logic            misalign,
    output logic            ras_empty
);
    pc_state_t       state, state_nxt;
    pc_sel_t         sel;
    logic [PC_W-1:0] pend_target, pend_nxt;
    logic [PC_W-1:0] tgt, pc_nxt, ras_top;
    logic            load, ras_push, ras_pop, ras_hit;

    assign pc_plus4    = pc + PC_W'(PC_INC);
    assign fetch_valid = (state != HALT);

`ifdef PC_UNIT_RAS_EN
    assign ras_hit = ret_pop && !ras_empty;

    pc_ras #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (ras_push),
        .pop   (ras_pop),
        .din   (pc_plus4),
        .top   (ras_top),
        .empty (ras_empty)
    );
`else
    localparam int unused_ras_depth = RAS_DEPTH;
    assign ras_hit   = 1'b0;
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    wire unused_ras = call_push ^ ret_pop ^ ras_push ^ ras_pop;
`endif

    always_comb begin
        sel       = SEL_HOLD;
        state_nxt = state;
        pend_nxt  = pend_target;
        ras_push  = 1'b0;
        ras_pop   = 1'b0;
        if (exc_valid) begin
            sel       = SEL_EXC;
            state_nxt = RUN;
        end else if (redir_valid && pc_wr) begin
            sel       = SEL_REDIR;
            state_nxt = RUN;
        end else if (state == HALT) begin
            sel = SEL_HOLD;
        end else if (redir_valid) begin
            pend_nxt  = redir_target;
            state_nxt = PEND;
        end else if (state == PEND) begin
            if (pc_wr) begin
                sel       = SEL_PEND;
                state_nxt = RUN;
            end
        end else if (pc_wr) begin
            // Only return/sequential cycles touch the stack.
            if (ras_hit) begin
                sel      = SEL_RAS;
                ras_pop  = 1'b1;
                ras_push = call_push;
            end else if (halt_req) begin
                state_nxt = HALT;
            end else begin
                sel      = SEL_SEQ;
                ras_push = call_push;
            end
        end
    end

    always_comb begin
        tgt = pc;
        case (sel)
            SEL_EXC:   tgt = EXC_VEC;
            SEL_REDIR: tgt = redir_target;
            SEL_PEND:  tgt = pend_target;
            SEL_RAS:   tgt = ras_top;
            SEL_SEQ:   tgt = pc_plus4;
            default:   tgt = pc;
        endcase
    end

    assign load   = (sel == SEL_EXC) || (sel == SEL_REDIR) || (sel == SEL_PEND) || (sel == SEL_RAS);
    assign pc_nxt = load ? {tgt[PC_W-1:2], 2'b00} : tgt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            pc          <= RESET_VEC;
            pend_target <= '0;
            flush       <= 1'b0;
            misalign    <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_target <= pend_nxt;
            flush       <= load;
            misalign    <= load && (tgt[1:0] != 2'b00);
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit; RAS scenarios run when
// PC_UNIT_RAS_EN is defined.
module tb_pc_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        pc_wr, redir_valid, exc_valid, halt_req, call_push, ret_pop;
    logic [31:0] redir_target;
    logic [31:0] pc, pc_plus4;
    logic        fetch_valid, flush, misalign, ras_empty;
    int          passed = 0;
    int          total  = 0;

    pc_unit dut (
        .clk(clk), .rst(rst), .pc_wr(pc_wr), .redir_valid(redir_valid),
        .redir_target(redir_target), .exc_valid(exc_valid), .halt_req(halt_req),
        .call_push(call_push), .ret_pop(ret_pop), .pc(pc), .pc_plus4(pc_plus4),
        .fetch_valid(fetch_valid), .flush(flush), .misalign(misalign), .ras_empty(ras_empty)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        pc_wr = 1'b0; redir_valid = 1'b0; exc_valid = 1'b0; halt_req = 1'b0;
        call_push = 1'b0; ret_pop = 1'b0; redir_target = 32'h0;
    endtask

    task automatic jump(input logic [31:0] t);
        idle_inputs();
        pc_wr = 1'b1; redir_valid = 1'b1; redir_target = t;
        tick();
        idle_inputs();
        total++; if (pc !== t) $display("FAIL jump pc=%h exp=%h", pc, t); else passed++;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b0;
        #12;
        total++; if (pc !== 32'h3000) $display("FAIL reset_pc pc=%h exp=3000", pc); else passed++;
        total++; if (pc_plus4 !== 32'h3004) $display("FAIL reset_pc4 got=%h exp=3004", pc_plus4); else passed++;
        total++; if ({fetch_valid, flush, misalign, ras_empty} !== 4'b1001)
            $display("FAIL reset_flags got=%b exp=1001", {fetch_valid, flush, misalign, ras_empty}); else passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_sequential;
        logic [31:0] exp [3];
        exp[0] = 32'h3004; exp[1] = 32'h3008; exp[2] = 32'h300C;
        pc_wr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pc !== exp[i] || flush !== 1'b0)
                $display("FAIL seq_%0d pc=%h flush=%b exp=%h/0", i, pc, flush, exp[i]); else passed++;
        end
    endtask

    task automatic test_pending;
        int flushes = 0;
        idle_inputs();
        redir_valid = 1'b1; redir_target = 32'h3100;
        tick();
        flushes += int'(flush);
        total++; if (pc !== 32'h300C) $display("FAIL pend_hold1 pc=%h exp=300c", pc); else passed++;
        redir_target = 32'h3200;
        tick();
        flushes += int'(flush);
        total++; if (pc !== 32'h300C) $display("FAIL pend_hold2 pc=%h exp=300c", pc); else passed++;
        idle_inputs();
        tick();
        total++; if (pc !== 32'h300C) $display("FAIL pend_stall pc=%h exp=300c", pc); else passed++;
        pc_wr = 1'b1;
        tick();
        flushes += int'(flush);
        total++; if (pc !== 32'h3200 || flush !== 1'b1)
            $display("FAIL pend_apply pc=%h flush=%b exp=3200/1", pc, flush); else passed++;
        tick();
        flushes += int'(flush);
        total++; if (pc !== 32'h3204) $display("FAIL pend_after pc=%h exp=3204", pc); else passed++;
        total++; if (flushes !== 1) $display("FAIL pend_flush_count got=%0d exp=1", flushes); else passed++;
    endtask

    task automatic test_exception;
        idle_inputs();
        exc_valid = 1'b1; redir_valid = 1'b1; redir_target = 32'h3100;
        tick();
        total++; if (pc !== 32'h4180 || flush !== 1'b1)
            $display("FAIL exc_load pc=%h flush=%b exp=4180/1", pc, flush); else passed++;
        idle_inputs();
        pc_wr = 1'b1;
        tick();
        total++; if (pc !== 32'h4184 || flush !== 1'b0)
            $display("FAIL exc_pend_cleared pc=%h flush=%b exp=4184/0", pc, flush); else passed++;
    endtask

    task automatic test_halt;
        jump(32'h3008);
        pc_wr = 1'b1; halt_req = 1'b1;
        tick();
        total++; if (pc !== 32'h3008 || fetch_valid !== 1'b0)
            $display("FAIL halt_enter pc=%h fv=%b exp=3008/0", pc, fetch_valid); else passed++;
        ret_pop = 1'b1; call_push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++; if (pc !== 32'h3008 || fetch_valid !== 1'b0 || flush !== 1'b0)
                $display("FAIL halt_frozen_%0d pc=%h fv=%b fl=%b exp=3008/0/0", i, pc, fetch_valid, flush); else passed++;
        end
        ret_pop = 1'b0; call_push = 1'b0;
        redir_valid = 1'b1; redir_target = 32'h3300;
        tick();
        total++; if (pc !== 32'h3300 || fetch_valid !== 1'b1 || flush !== 1'b1)
            $display("FAIL halt_exit pc=%h fv=%b fl=%b exp=3300/1/1", pc, fetch_valid, flush); else passed++;
        idle_inputs();
        pc_wr = 1'b1;
        tick();
        total++; if (pc !== 32'h3304) $display("FAIL halt_run pc=%h exp=3304", pc); else passed++;
        halt_req = 1'b1;
        tick();
        idle_inputs();
        exc_valid = 1'b1;
        tick();
        total++; if (pc !== 32'h4180 || fetch_valid !== 1'b1)
            $display("FAIL halt_exc pc=%h fv=%b exp=4180/1", pc, fetch_valid); else passed++;
        idle_inputs();
    endtask

    task automatic test_misalign;
        idle_inputs();
        pc_wr = 1'b1; redir_valid = 1'b1; redir_target = 32'h3102;
        tick();
        total++; if (pc !== 32'h3100 || misalign !== 1'b1 || flush !== 1'b1)
            $display("FAIL misalign_load pc=%h mis=%b fl=%b exp=3100/1/1", pc, misalign, flush); else passed++;
        idle_inputs();
        pc_wr = 1'b1;
        tick();
        total++; if (pc !== 32'h3104 || misalign !== 1'b0 || flush !== 1'b0)
            $display("FAIL misalign_clear pc=%h mis=%b fl=%b exp=3104/0/0", pc, misalign, flush); else passed++;
        redir_valid = 1'b1; redir_target = 32'h3200;
        tick();
        total++; if (pc !== 32'h3200 || misalign !== 1'b0)
            $display("FAIL aligned_redir pc=%h mis=%b exp=3200/0", pc, misalign); else passed++;
    endtask

    task automatic test_wrap;
        jump(32'hFFFF_FFFC);
        pc_wr = 1'b1;
        total++; if (pc_plus4 !== 32'h0) $display("FAIL wrap_pc4 got=%h exp=0", pc_plus4); else passed++;
        tick();
        total++; if (pc !== 32'h0) $display("FAIL wrap_pc pc=%h exp=0", pc); else passed++;
    endtask

    task automatic test_reset_mid;
        idle_inputs();
        redir_valid = 1'b1; redir_target = 32'h3100;
        tick();
        rst = 1'b0;
        #1;
        total++; if (pc !== 32'h3000 || fetch_valid !== 1'b1)
            $display("FAIL async_reset pc=%h fv=%b exp=3000/1", pc, fetch_valid); else passed++;
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
        pc_wr = 1'b1;
        tick();
        total++; if (pc !== 32'h3004 || flush !== 1'b0)
            $display("FAIL reset_drops_pend pc=%h fl=%b exp=3004/0", pc, flush); else passed++;
    endtask

`ifdef PC_UNIT_RAS_EN
    task automatic test_ras_calls;
        jump(32'h3000);
        pc_wr = 1'b1; call_push = 1'b1;
        tick();
        call_push = 1'b0;
        tick(); tick(); tick();
        total++; if (pc !== 32'h3010) $display("FAIL ras_pc_call2 pc=%h exp=3010", pc); else passed++;
        call_push = 1'b1;
        tick();
        call_push = 1'b0; ret_pop = 1'b1;
        tick();
        total++; if (pc !== 32'h3014 || flush !== 1'b1)
            $display("FAIL ras_pop1 pc=%h fl=%b exp=3014/1", pc, flush); else passed++;
        tick();
        total++; if (pc !== 32'h3004 || ras_empty !== 1'b1)
            $display("FAIL ras_pop2 pc=%h empty=%b exp=3004/1", pc, ras_empty); else passed++;
        tick();
        total++; if (pc !== 32'h3008 || flush !== 1'b0)
            $display("FAIL ras_pop_empty pc=%h fl=%b exp=3008/0", pc, flush); else passed++;
        idle_inputs();
    endtask

    task automatic test_ras_overflow;
        logic [31:0] exp [4];
        exp[0] = 32'h5014; exp[1] = 32'h5010; exp[2] = 32'h500C; exp[3] = 32'h5008;
        jump(32'h5000);
        pc_wr = 1'b1; call_push = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        call_push = 1'b0;
        tick();
        total++; if (pc !== 32'h5018) $display("FAIL ras_ovf_pc pc=%h exp=5018", pc); else passed++;
        ret_pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (pc !== exp[i]) $display("FAIL ras_ovf_pop%0d pc=%h exp=%h", i, pc, exp[i]); else passed++;
        end
        total++; if (ras_empty !== 1'b1) $display("FAIL ras_ovf_empty got=%b exp=1", ras_empty); else passed++;
        idle_inputs();
    endtask
`endif

    initial begin
        test_reset();
        test_sequential();
        test_pending();
        test_exception();
        test_halt();
        test_misalign();
        test_wrap();
        test_reset_mid();
`ifdef PC_UNIT_RAS_EN
        test_ras_calls();
        test_ras_overflow();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter stage for the pipelined CPU front end.
- Successor to the plain PC register. Adds:
  - prioritised next-PC selection: exception, redirect, pending redirect, sequential;
  - a redirect that arrives during a stall is held and applied when the stall ends;
  - a halt state;
  - a flush pulse to the IF/ID register.
- Sits between the hazard/branch logic and instruction-memory fetch.

Parameters:
- PC_W, 32, PC width in bits; arithmetic wraps modulo 2^PC_W.
- RESET_VEC, 32'h0000_3000, PC value on reset (PC_W bits).
- EXC_VEC, 32'h0000_4180, exception handler entry.
- RAS_DEPTH, 4, return-address-stack entries; power of 2, at least 2. Used only with RAS_EN.

Ports:
- clk, input, 1, clock; rising edge.
- rst, input, 1, asynchronous active-low reset.
- pc_wr, input, 1, advance enable; 0 = stall and hold pc.
- redir_valid, input, 1, branch/jump resolved taken.
- redir_target, input, PC_W, redirect address.
- exc_valid, input, 1, exception request.
- halt_req, input, 1, request to halt fetch.
- call_push, input, 1, push pc_plus4 onto the RAS (RAS_EN only).
- ret_pop, input, 1, predict return target from the RAS (RAS_EN only).
- pc, output, PC_W, current fetch address.
- pc_plus4, output, PC_W, pc+4, combinational from pc.
- fetch_valid, output, 1, pc is a valid fetch (0 in HALT).
- flush, output, 1, registered one-cycle pulse after any non-sequential load.
- misalign, output, 1, registered one-cycle pulse when a loaded target had bits [1:0] nonzero.
- ras_empty, output, 1, RAS holds no entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_VEC, state=RUN, pend_valid=0;
  - flush=0, misalign=0, fetch_valid=1;
  - RAS pointer=0, count=0, ras_empty=1.
- States:
  - RUN: normal fetch.
  - PEND: a redirect is stored in pend_target.
  - HALT: fetch stopped.
- Next-PC priority, evaluated every cycle:
  1. exc_valid: load EXC_VEC, even when pc_wr=0 or in HALT. Clears pending. Goes to RUN.
  2. redir_valid with pc_wr=1: load redir_target. Clears pending. Goes to RUN; this also exits HALT.
  3. redir_valid with pc_wr=0: store redir_target in pend_target; the newest redirect overwrites the old one. Go to PEND; pc holds.
  4. PEND with pc_wr=1: load pend_target. Go to RUN.
  5. ret_pop with pc_wr=1 (RAS_EN only): load the RAS top.
  6. halt_req with pc_wr=1 in RUN: pc holds. Go to HALT.
  7. pc_wr=1 in RUN: pc <= pc+4, wrapping.
  8. Otherwise pc holds.
- Target alignment:
  - Every loaded target is forced to bits [1:0]=0.
  - misalign pulses the cycle after the load when the original target had bits [1:0] nonzero.
- flush:
  - Pulses the cycle after cases 1, 2, 4 and 5.
  - Does not pulse on sequential advance, on hold, or on store-only (case 3).
- HALT:
  - fetch_valid=0; pc frozen.
  - halt_req, call_push and ret_pop are ignored.
  - Left only through case 1 or case 2.
- Latency: one cycle from any input to pc, flush and misalign.
- Reset mid-operation discards the pending redirect and the RAS contents.

Optional Feature:
- Macro: PC_UNIT_RAS_EN.
- Defined:
  - Circular return-address stack, RAS_DEPTH entries.
  - call_push with pc_wr=1 pushes pc_plus4.
  - Overflow overwrites the oldest entry; count saturates at RAS_DEPTH.
  - ret_pop with pc_wr=1 pops and loads the top (case 5).
  - Pop when empty: pc takes the sequential path and the pointer is unchanged.
  - Push and pop in the same cycle: the top is loaded into pc, then replaced by pc_plus4; count is unchanged.
  - The RAS is only updated when the cycle resolves to case 5 or case 7. Any higher-priority event suppresses the update.
- Undefined:
  - call_push and ret_pop are ignored; ras_empty is tied to 1.
  - No RAS storage is synthesised.

Decomposition:
- Package pc_unit_pkg:
  - state enum {RUN, PEND, HALT};
  - next-PC select enum {SEL_EXC, SEL_REDIR, SEL_PEND, SEL_RAS, SEL_SEQ, SEL_HOLD};
  - constant PC_INC=4.
- Sub-module pc_ras: the circular stack with push, pop, top and empty. Instantiated only under PC_UNIT_RAS_EN.

Test Plan:
- Reset release, pc_wr=1 for 3 cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; flush=0 throughout.
- Set pc_wr=0 and redir_valid with 0x3100, then 0x3200 while still stalled, then pc_wr=1 -> pc holds, then loads 0x3200; flush pulses once.
- exc_valid together with redir_valid=0x3100 while pc_wr=0 -> pc=0x4180 next cycle; pending cleared; flush=1.
- halt_req at pc=0x3008 -> pc frozen and fetch_valid=0 for 5 cycles; then redir 0x3300 with pc_wr=1 -> RUN, pc=0x3300.
- redir_target=0x3102 -> pc=0x3100; misalign and flush pulse together.
- With PC_UNIT_RAS_EN:
  - calls at pc 0x3000 and 0x3010, then two pops -> pc 0x3014, then 0x3004; ras_empty=1 afterwards;
  - 5 pushes with depth 4, then a pop -> pc = the last push.
